// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared types and encodings for multicycle_ctrl (S_TRAP exists only with OVERFLOW_TRAP_EN)
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_INIT, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEM_ADDR, S_MEM_RD,
    S_MEM_WR, S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP
`ifdef OVERFLOW_TRAP_EN
    , S_TRAP
`endif
  } state_t;

  // Which ALU operation family the current state asks of the ALU decoder
  typedef enum logic [2:0] {CLS_NONE, CLS_R, CLS_I, CLS_MEM, CLS_BR} alu_cls_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] BR_PC4  = 2'b00;
  localparam logic [1:0] BR_BTA  = 2'b01;
  localparam logic [1:0] BR_JUMP = 2'b10;

  localparam logic [1:0] D2R_ALU = 2'b00;
  localparam logic [1:0] D2R_MEM = 2'b01;
  localparam logic [1:0] D2R_PC4 = 2'b10;

  function automatic logic op_legal(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_ADDI, OP_SLTI, OP_LW, OP_SW,
      OP_BEQ, OP_BNE, OP_J, OP_JAL: return 1'b1;
      default:                      return 1'b0;
    endcase
  endfunction

  // Signed-arithmetic instructions whose overflow may trap
  function automatic logic ovf_op(input logic [5:0] op, input logic [5:0] funct);
    return (op == OP_ADDI) ||
           ((op == OP_RTYPE) && ((funct == FN_ADD) || (funct == FN_SUB)));
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - controller <-> datapath/memory signal bundle
interface multicycle_ctrl_if #(parameter int CNT_W = 32);
  logic [5:0]       op;
  logic [5:0]       funct;
  logic             zero;
  logic             overflow;
  logic             mem_ack;
  logic             mem_req;
  logic             mem_we;
  logic             mem_sel_d;
  logic             IR_write;
  logic             PC_write;
  logic [1:0]       Branch;
  logic [2:0]       ALU_Control;
  logic             ALUSrc_B;
  logic             RegWrite;
  logic             RegDst;
  logic [1:0]       DatatoReg;
  logic             Jal;
  logic             illegal;
  logic [CNT_W-1:0] retired;

  modport master (
    input  op, funct, zero, overflow, mem_ack,
    output mem_req, mem_we, mem_sel_d, IR_write, PC_write, Branch, ALU_Control,
           ALUSrc_B, RegWrite, RegDst, DatatoReg, Jal, illegal, retired
  );

  modport slave (
    output op, funct, zero, overflow, mem_ack,
    input  mem_req, mem_we, mem_sel_d, IR_write, PC_write, Branch, ALU_Control,
           ALUSrc_B, RegWrite, RegDst, DatatoReg, Jal, illegal, retired
  );
endinterface

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - ALU operation select from state class, opcode and funct
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  alu_cls_t   i_cls,
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  output logic [2:0] o_alu_ctrl,
  output logic       o_funct_illegal
);

  // Map the requesting state class to an ALU operation; unknown R-type funct is flagged
  always_comb begin
    o_alu_ctrl      = ALU_AND;
    o_funct_illegal = 1'b0;
    case (i_cls)
      CLS_R: begin
        case (i_funct)
          FN_ADD:  o_alu_ctrl = ALU_ADD;
          FN_SUB:  o_alu_ctrl = ALU_SUB;
          FN_AND:  o_alu_ctrl = ALU_AND;
          FN_OR:   o_alu_ctrl = ALU_OR;
          FN_SLT:  o_alu_ctrl = ALU_SLT;
          default: o_funct_illegal = 1'b1;
        endcase
      end
      CLS_I:   o_alu_ctrl = (i_op == OP_SLTI) ? ALU_SLT : ALU_ADD;
      CLS_MEM: o_alu_ctrl = ALU_ADD;
      CLS_BR:  o_alu_ctrl = ALU_SUB;
      default: o_alu_ctrl = ALU_AND;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle MIPS control FSM; OVERFLOW_TRAP_EN adds the overflow TRAP state
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input logic               clk,
  input logic               rst,
  multicycle_ctrl_if.master bus
);

  state_t           r_state;
  logic [5:0]       r_op;
  logic [5:0]       r_funct;
  logic [CNT_W-1:0] r_retired;

  alu_cls_t   w_cls;
  logic [2:0] w_alu_ctrl;
  logic       w_funct_illegal;
  logic       w_ovf_trap;

`ifdef OVERFLOW_TRAP_EN
  assign w_ovf_trap = bus.overflow && ovf_op(r_op, r_funct);
`else
  logic w_unused_ovf;
  assign w_unused_ovf = bus.overflow;
  assign w_ovf_trap   = 1'b0;
`endif

  // ALU class requested by the current state
  always_comb begin
    w_cls = CLS_NONE;
    case (r_state)
      S_EXEC_R:   w_cls = CLS_R;
      S_EXEC_I:   w_cls = CLS_I;
      S_MEM_ADDR: w_cls = CLS_MEM;
      S_BRANCH:   w_cls = CLS_BR;
      default:    w_cls = CLS_NONE;
    endcase
  end

  alu_decoder u_alu_decoder (
    .i_cls           (w_cls),
    .i_op            (r_op),
    .i_funct         (r_funct),
    .o_alu_ctrl      (w_alu_ctrl),
    .o_funct_illegal (w_funct_illegal)
  );

  // State sequencing, opcode/funct capture at DECODE and retired-instruction count
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_INIT;
      r_op      <= '0;
      r_funct   <= '0;
      r_retired <= '0;
    end else begin
      case (r_state)
        S_INIT:  r_state <= S_FETCH;
        S_FETCH: if (bus.mem_ack) r_state <= S_DECODE;
        S_DECODE: begin
          r_op    <= bus.op;
          r_funct <= bus.funct;
          case (bus.op)
            OP_RTYPE:        r_state <= S_EXEC_R;
            OP_ADDI, OP_SLTI: r_state <= S_EXEC_I;
            OP_LW, OP_SW:    r_state <= S_MEM_ADDR;
            OP_BEQ, OP_BNE:  r_state <= S_BRANCH;
            OP_J, OP_JAL:    r_state <= S_JUMP;
            default:         r_state <= S_FETCH;
          endcase
        end
        S_EXEC_R: begin
          if (w_funct_illegal) r_state <= S_FETCH;
`ifdef OVERFLOW_TRAP_EN
          else if (w_ovf_trap) r_state <= S_TRAP;
`endif
          else                 r_state <= S_WB_ALU;
        end
        S_EXEC_I: begin
`ifdef OVERFLOW_TRAP_EN
          if (w_ovf_trap) r_state <= S_TRAP;
          else            r_state <= S_WB_ALU;
`else
          r_state <= S_WB_ALU;
`endif
        end
        S_MEM_ADDR: r_state <= (r_op == OP_LW) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:   if (bus.mem_ack) r_state <= S_WB_MEM;
        S_MEM_WR: begin
          if (bus.mem_ack) begin
            r_state   <= S_FETCH;
            r_retired <= r_retired + CNT_W'(1);
          end
        end
        S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP: begin
          r_state   <= S_FETCH;
          r_retired <= r_retired + CNT_W'(1);
        end
`ifdef OVERFLOW_TRAP_EN
        S_TRAP: r_state <= S_FETCH;
`endif
        default: r_state <= S_INIT;
      endcase
    end
  end

  // Moore decode of datapath controls; FETCH ack strobes and branch PC_write follow their inputs
  always_comb begin
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_sel_d = 1'b0;
    bus.IR_write  = 1'b0;
    bus.PC_write  = 1'b0;
    bus.Branch    = BR_PC4;
    bus.ALUSrc_B  = 1'b0;
    bus.RegWrite  = 1'b0;
    bus.RegDst    = 1'b0;
    bus.DatatoReg = D2R_ALU;
    bus.Jal       = 1'b0;
    bus.illegal   = 1'b0;
    case (r_state)
      S_FETCH: begin
        bus.mem_req  = 1'b1;
        bus.IR_write = bus.mem_ack;
        bus.PC_write = bus.mem_ack;
      end
      S_DECODE: bus.illegal = !op_legal(bus.op);
      S_EXEC_R: begin
        bus.RegDst  = 1'b1;
        bus.illegal = w_funct_illegal;
      end
      S_EXEC_I, S_MEM_ADDR: bus.ALUSrc_B = 1'b1;
      S_MEM_RD: begin
        bus.mem_req   = 1'b1;
        bus.mem_sel_d = 1'b1;
      end
      S_MEM_WR: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_sel_d = 1'b1;
      end
      S_WB_ALU: begin
        bus.RegWrite = 1'b1;
        bus.RegDst   = (r_op == OP_RTYPE);
      end
      S_WB_MEM: begin
        bus.RegWrite  = 1'b1;
        bus.DatatoReg = D2R_MEM;
      end
      S_BRANCH: begin
        bus.Branch   = BR_BTA;
        bus.PC_write = (r_op == OP_BEQ) ? bus.zero : !bus.zero;
      end
      S_JUMP: begin
        bus.Branch   = BR_JUMP;
        bus.PC_write = 1'b1;
        if (r_op == OP_JAL) begin
          bus.Jal       = 1'b1;
          bus.RegWrite  = 1'b1;
          bus.DatatoReg = D2R_PC4;
        end
      end
`ifdef OVERFLOW_TRAP_EN
      S_TRAP: bus.illegal = 1'b1;
`endif
      default: bus.mem_req = 1'b0;
    endcase
  end

  assign bus.ALU_Control = w_alu_ctrl;
  assign bus.retired     = r_retired;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  multicycle_ctrl_if #(.CNT_W(32)) bus ();

  multicycle_ctrl #(.CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // {req, we, sel_d, IR_write, PC_write, Branch, ALU_Control, ALUSrc_B, RegWrite, RegDst, DatatoReg, Jal, illegal}
  logic [16:0] ctl;
  assign ctl = {bus.mem_req, bus.mem_we, bus.mem_sel_d, bus.IR_write, bus.PC_write,
                bus.Branch, bus.ALU_Control, bus.ALUSrc_B, bus.RegWrite, bus.RegDst,
                bus.DatatoReg, bus.Jal, bus.illegal};

  function automatic logic [16:0] ex(input logic req, we, sel, irw, pcw,
                                     input logic [1:0] br, input logic [2:0] alu,
                                     input logic srcb, rw, rd, input logic [1:0] d2r,
                                     input logic jal, ill);
    return {req, we, sel, irw, pcw, br, alu, srcb, rw, rd, d2r, jal, ill};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Present mem_ack for the current cycle, check the controls, advance one clock
  task automatic cyc(input string tag, input logic ack, input logic [16:0] exp);
    bus.mem_ack = ack;
    #1;
    check(tag, 32'(ctl), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  logic [16:0] C0, F_ACK, F_WAIT, MR, MW, MA;

  initial begin
    C0     = '0;
    F_ACK  = ex(1,0,0,1,1,2'b00,3'b000,0,0,0,2'b00,0,0);
    F_WAIT = ex(1,0,0,0,0,2'b00,3'b000,0,0,0,2'b00,0,0);
    MR     = ex(1,0,1,0,0,2'b00,3'b000,0,0,0,2'b00,0,0);
    MW     = ex(1,1,1,0,0,2'b00,3'b000,0,0,0,2'b00,0,0);
    MA     = ex(0,0,0,0,0,2'b00,3'b010,1,0,0,2'b00,0,0);

    bus.op = 6'h00; bus.funct = 6'h00; bus.zero = 1'b0;
    bus.overflow = 1'b0; bus.mem_ack = 1'b0;

    // reset held for two edges
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    check("rst_ctl", 32'(ctl), 32'(C0));
    check("rst_retired", bus.retired, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // add, zero-wait: 4 cycles
    bus.op = 6'h00; bus.funct = 6'h20;
    cyc("add_fetch", 1, F_ACK);
    cyc("add_dec",   0, C0);
    cyc("add_exec",  0, ex(0,0,0,0,0,2'b00,3'b010,0,0,1,2'b00,0,0));
    cyc("add_wb",    0, ex(0,0,0,0,0,2'b00,3'b000,0,1,1,2'b00,0,0));
    check("add_retired", bus.retired, 1);

    // lw with 3 data wait cycles: 8 cycles
    bus.op = 6'h23;
    cyc("lw_fetch", 1, F_ACK);
    cyc("lw_dec",   0, C0);
    cyc("lw_addr",  0, MA);
    for (int i = 0; i < 3; i++) cyc("lw_rd_wait", 0, MR);
    cyc("lw_rd_ack", 1, MR);
    cyc("lw_wb",     0, ex(0,0,0,0,0,2'b00,3'b000,0,1,0,2'b01,0,0));
    check("lw_retired", bus.retired, 2);

    // sw with one fetch wait; ack in DECODE is ignored
    bus.op = 6'h2B;
    cyc("sw_fetch_wait", 0, F_WAIT);
    cyc("sw_fetch",      1, F_ACK);
    cyc("sw_dec_ack",    1, C0);
    cyc("sw_addr",       0, MA);
    cyc("sw_wr",         1, MW);
    check("sw_retired", bus.retired, 3);

    // beq taken / not taken, bne with zero=0
    bus.op = 6'h04; bus.zero = 1'b1;
    cyc("beq1_fetch", 1, F_ACK);
    cyc("beq1_dec",   0, C0);
    cyc("beq1_br",    0, ex(0,0,0,0,1,2'b01,3'b110,0,0,0,2'b00,0,0));
    bus.zero = 1'b0;
    cyc("beq0_fetch", 1, F_ACK);
    cyc("beq0_dec",   0, C0);
    cyc("beq0_br",    0, ex(0,0,0,0,0,2'b01,3'b110,0,0,0,2'b00,0,0));
    bus.op = 6'h05;
    cyc("bne_fetch", 1, F_ACK);
    cyc("bne_dec",   0, C0);
    cyc("bne_br",    0, ex(0,0,0,0,1,2'b01,3'b110,0,0,0,2'b00,0,0));
    check("br_retired", bus.retired, 6);

    // jal and j
    bus.op = 6'h03;
    cyc("jal_fetch", 1, F_ACK);
    cyc("jal_dec",   0, C0);
    cyc("jal_jump",  0, ex(0,0,0,0,1,2'b10,3'b000,0,1,0,2'b10,1,0));
    bus.op = 6'h02;
    cyc("j_fetch", 1, F_ACK);
    cyc("j_dec",   0, C0);
    cyc("j_jump",  0, ex(0,0,0,0,1,2'b10,3'b000,0,0,0,2'b00,0,0));
    check("j_retired", bus.retired, 8);

    // illegal opcode: pulse in DECODE, back to FETCH, no retire
    bus.op = 6'h3F;
    cyc("ill_fetch", 1, F_ACK);
    cyc("ill_dec",   0, ex(0,0,0,0,0,2'b00,3'b000,0,0,0,2'b00,0,1));
    check("ill_retired", bus.retired, 8);

    // slti
    bus.op = 6'h0A;
    cyc("slti_fetch", 1, F_ACK);
    cyc("slti_dec",   0, C0);
    cyc("slti_exec",  0, ex(0,0,0,0,0,2'b00,3'b111,1,0,0,2'b00,0,0));
    cyc("slti_wb",    0, ex(0,0,0,0,0,2'b00,3'b000,0,1,0,2'b00,0,0));
    check("slti_retired", bus.retired, 9);

    // R-type with unknown funct
    bus.op = 6'h00; bus.funct = 6'h3F;
    cyc("badfn_fetch", 1, F_ACK);
    cyc("badfn_dec",   0, C0);
    cyc("badfn_exec",  0, ex(0,0,0,0,0,2'b00,3'b000,0,0,1,2'b00,0,1));
    check("badfn_retired", bus.retired, 9);
    cyc("badfn_next", 0, F_WAIT);

    // addi with overflow
    bus.op = 6'h08; bus.overflow = 1'b1;
    cyc("addi_fetch", 1, F_ACK);
    cyc("addi_dec",   0, C0);
    cyc("addi_exec",  0, ex(0,0,0,0,0,2'b00,3'b010,1,0,0,2'b00,0,0));
`ifdef OVERFLOW_TRAP_EN
    cyc("addi_trap",  0, ex(0,0,0,0,0,2'b00,3'b000,0,0,0,2'b00,0,1));
    check("addi_retired", bus.retired, 9);
`else
    cyc("addi_wb",    0, ex(0,0,0,0,0,2'b00,3'b000,0,1,0,2'b00,0,0));
    check("addi_retired", bus.retired, 10);
`endif
    bus.overflow = 1'b0;

    // reset during MEM_WR wait
    bus.op = 6'h2B;
    cyc("swr_fetch", 1, F_ACK);
    cyc("swr_dec",   0, C0);
    cyc("swr_addr",  0, MA);
    bus.mem_ack = 1'b0;
    #1;
    check("swr_wait", 32'(ctl), 32'(MW));
    rst = 1'b1;
    @(posedge clk); #1;
    check("swr_rst_ctl", 32'(ctl), 32'(C0));
    check("swr_rst_retired", bus.retired, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("swr_refetch", 32'(ctl), 32'(F_WAIT));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
